// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the instruction sequencer:
//   - instruction field positions within the 10-bit instruction word
//   - opcode constants
//   - FSM state enum and decoded instruction-class enum
//   - helper to sign-extend the 2-bit branch offset to pc width
// No ports (package).
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int INSTR_W = 10;
    localparam int PC_W    = 8;

    // Instruction layout: op[9:6], rAlpha[5:4], rBeta[3:2], rGamma[1:0]
    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int RA_MSB = 5;
    localparam int RA_LSB = 4;
    localparam int RB_MSB = 3;
    localparam int RB_LSB = 2;
    localparam int RG_MSB = 1;
    localparam int RG_LSB = 0;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP     = 3'd0,
        CL_ALU     = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BEQ     = 3'd4,
        CL_HALT    = 3'd5,
        CL_ILLEGAL = 3'd6
    } iclass_t;

    // rGamma is a two's-complement offset in -2..+1
    function automatic logic [PC_W-1:0] sext_off(input logic [1:0] off);
        return {{(PC_W-2){off[1]}}, off};
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Groups the sequencer's fetch bus, data bus, datapath control and status
// signals.
//   master : the sequencer (drives requests, pc, control; receives acks,
//            instruction data and alu_zero)
//   slave  : memories / datapath / testbench side
// ---------------------------------------------------------------------------
interface instr_sequencer_if;
    import seq_pkg::*;

    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    pc;
    logic               track_select;
    logic [1:0]         r_alpha;
    logic [1:0]         r_beta;
    logic [1:0]         r_gamma;
    logic [2:0]         alu_op;
    logic               reg_we;
    logic               wb_sel;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic               alu_zero;
    logic               halted;
    logic               illegal;

    modport master (
        output imem_req, pc, track_select, r_alpha, r_beta, r_gamma, alu_op,
               reg_we, wb_sel, dmem_req, dmem_we, halted, illegal,
        input  imem_ack, imem_rdata, dmem_ack, alu_zero
    );

    modport slave (
        input  imem_req, pc, track_select, r_alpha, r_beta, r_gamma, alu_op,
               reg_we, wb_sel, dmem_req, dmem_we, halted, illegal,
        output imem_ack, imem_rdata, dmem_ack, alu_zero
    );

endinterface

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Purely combinational opcode classification.
//   i_op      in  4  opcode field of the instruction register
//   o_class   out    instruction class (ALU/LOAD/STORE/BEQ/NOP/HALT/ILLEGAL)
//   o_alu_op  out 3  op[2:0] for ALU opcodes, 000 otherwise
//   o_illegal out 1  opcode is in the reserved range 0xB..0xE
// ---------------------------------------------------------------------------
module instr_decode
    import seq_pkg::*;
(
    input  logic [3:0] i_op,
    output iclass_t    o_class,
    output logic [2:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_class   = CL_NOP;
        o_alu_op  = 3'b000;
        o_illegal = 1'b0;
        case (i_op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                o_class  = CL_ALU;
                o_alu_op = i_op[2:0];
            end
            OP_NOP:   o_class = CL_NOP;
            OP_LOAD:  o_class = CL_LOAD;
            OP_STORE: o_class = CL_STORE;
            OP_BEQ:   o_class = CL_BEQ;
            OP_HALT:  o_class = CL_HALT;
            default: begin
                // Reserved opcodes execute as NOP but are flagged
                o_class   = CL_ILLEGAL;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB,
// with an absorbing HALT state.
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   bus     if   instr_sequencer_if.master: fetch bus (imem_*), pc, register
//                fields/track/alu_op of the latched IR, reg_we/wb_sel,
//                data bus (dmem_*), alu_zero, halted, illegal
// ---------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    instr_sequencer_if.master bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic               r_started;
    logic               w_enter_fetch;
    logic               w_fetch_done;

    iclass_t            w_class;
    logic [2:0]         w_alu_op;
    logic               w_illegal;

    instr_decode u_decode (
        .i_op      (r_ir[OP_MSB:OP_LSB]),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    // r_started keeps imem_req low while reset is held and for the reset
    // release cycle; the first request appears one clock after release.
    assign w_fetch_done = (r_state == FETCH) && r_started && bus.imem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_state   <= w_state_next;
            if (w_fetch_done) begin
                r_ir <= bus.imem_rdata;
            end
            if (w_enter_fetch) begin
                r_pc <= w_pc_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc + 8'd1;
        case (r_state)
            FETCH: begin
                if (w_fetch_done) begin
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                case (w_class)
                    CL_ALU, CL_LOAD, CL_STORE, CL_BEQ: w_state_next = EXEC;
                    CL_HALT:                           w_state_next = HALT;
                    default:                           w_state_next = FETCH;
                endcase
            end
            EXEC: begin
                case (w_class)
                    CL_ALU:           w_state_next = WB;
                    CL_LOAD, CL_STORE: w_state_next = MEM;
                    default:          w_state_next = FETCH;
                endcase
                // Branch target is resolved here because alu_zero is only
                // meaningful during EXEC.
                if ((w_class == CL_BEQ) && bus.alu_zero) begin
                    w_pc_next = r_pc + 8'd1 + sext_off(r_ir[RG_MSB:RG_LSB]);
                end
            end
            MEM: begin
                if (bus.dmem_ack) begin
                    w_state_next = (w_class == CL_STORE) ? FETCH : WB;
                end
            end
            WB:      w_state_next = FETCH;
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
        // pc advances exactly once per instruction, on the way back to FETCH
        w_enter_fetch = (w_state_next == FETCH) && (r_state != FETCH);
    end

    // Moore outputs decoded from the state register and IR so that an
    // asserted reset removes every request immediately.
    assign bus.imem_req     = (r_state == FETCH) && r_started;
    assign bus.pc           = r_pc;
    assign bus.track_select = (w_class == CL_ALU);
    assign bus.r_alpha      = r_ir[RA_MSB:RA_LSB];
    assign bus.r_beta       = r_ir[RB_MSB:RB_LSB];
    assign bus.r_gamma      = r_ir[RG_MSB:RG_LSB];
    assign bus.alu_op       = w_alu_op;
    assign bus.reg_we       = (r_state == WB);
    assign bus.wb_sel       = (w_class == CL_LOAD);
    assign bus.dmem_req     = (r_state == MEM);
    assign bus.dmem_we      = (r_state == MEM) && (w_class == CL_STORE);
    assign bus.halted       = (r_state == HALT);
    assign bus.illegal      = (r_state == DECODE) && w_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. Each instruction run pushes its
// predicted outcome to a scoreboard queue; the outcome observed on the bus is
// compared against the popped prediction when the DUT returns to FETCH.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    logic clk;
    logic reset_n;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    logic [7:0] m_pc;

    typedef struct {
        int         cycles;
        int         we_cnt;
        int         we_cyc;
        bit         wb_sel;
        int         dm_cnt;
        bit         dm_we;
        int         ill_cnt;
        bit         trk;
        logic [2:0] aop;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [9:0] ins, input logic [7:0] pc,
                                     input bit zero, input int iw, input int dw);
        exp_t e;
        logic [3:0] op;
        int base;
        op = ins[9:6];
        base = iw + 2;            // fetch cycles plus one DECODE cycle
        e.cycles = base; e.we_cnt = 0; e.we_cyc = 0; e.wb_sel = 0;
        e.dm_cnt = 0; e.dm_we = 0; e.ill_cnt = 0; e.trk = 0; e.aop = 3'b000;
        e.pc = pc + 8'd1;
        if (op >= 4'h1 && op <= 4'h7) begin
            e.cycles = base + 2; e.we_cnt = 1; e.trk = 1; e.aop = op[2:0];
        end else if (op == 4'h8) begin
            e.cycles = base + 1 + (dw + 1) + 1; e.we_cnt = 1; e.wb_sel = 1; e.dm_cnt = dw + 1;
        end else if (op == 4'h9) begin
            e.cycles = base + 1 + (dw + 1); e.dm_cnt = dw + 1; e.dm_we = 1;
        end else if (op == 4'hA) begin
            e.cycles = base + 1;
            if (zero) e.pc = pc + 8'd1 + {{6{ins[1]}}, ins[1:0]};
        end else if (op >= 4'hB && op <= 4'hE) begin
            e.ill_cnt = 1;
        end
        if (e.we_cnt != 0) e.we_cyc = e.cycles;
        return e;
    endfunction

    // Runs one instruction starting at a negedge with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [9:0] ins,
                             input int iw, input int dw, input bit zero);
        exp_t e, o;
        int cyc, iwc, dwc;
        bit fetched, done, ovl;
        sb.push_back(predict(ins, m_pc, zero, iw, dw));
        o.we_cnt = 0; o.we_cyc = 0; o.wb_sel = 0; o.dm_cnt = 0; o.dm_we = 0;
        o.ill_cnt = 0; o.trk = 0; o.aop = 3'b000;
        cyc = 0; iwc = 0; dwc = 0; fetched = 0; done = 0; ovl = 0;
        while (!done && cyc < 64) begin
            cyc++;
            if (bus.reg_we) begin o.we_cnt++; o.we_cyc = cyc; o.wb_sel = bus.wb_sel; end
            if (bus.dmem_req) begin o.dm_cnt++; if (bus.dmem_we) o.dm_we = 1; end
            if (bus.illegal) o.ill_cnt++;
            if ((int'(bus.reg_we) + int'(bus.dmem_req) + int'(bus.imem_req)) > 1) ovl = 1;
            if (cyc == iw + 2) begin o.trk = bus.track_select; o.aop = bus.alu_op; end
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            bus.alu_zero = zero;
            bus.imem_rdata = ins;
            if (bus.imem_req && !fetched) begin
                if (iwc == iw) begin bus.imem_ack = 1'b1; fetched = 1; end
                iwc++;
            end
            if (bus.dmem_req) begin
                if (dwc == dw) bus.dmem_ack = 1'b1;
                dwc++;
            end
            @(negedge clk);
            if (fetched && bus.imem_req) done = 1;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        o.cycles = cyc;
        o.pc = bus.pc;
        e = sb.pop_front();
        check({name, ".done"},    32'(done),     32'd1);
        check({name, ".cycles"},  o.cycles,      e.cycles);
        check({name, ".we_cnt"},  o.we_cnt,      e.we_cnt);
        check({name, ".we_cyc"},  o.we_cyc,      e.we_cyc);
        check({name, ".wb_sel"},  32'(o.wb_sel), 32'(e.wb_sel));
        check({name, ".dm_cnt"},  o.dm_cnt,      e.dm_cnt);
        check({name, ".dm_we"},   32'(o.dm_we),  32'(e.dm_we));
        check({name, ".illegal"}, o.ill_cnt,     e.ill_cnt);
        check({name, ".track"},   32'(o.trk),    32'(e.trk));
        check({name, ".alu_op"},  32'(o.aop),    32'(e.aop));
        check({name, ".pc"},      32'(o.pc),     32'(e.pc));
        check({name, ".overlap"}, 32'(ovl),      32'd0);
        m_pc = e.pc;
        $display("txn %-12s instr=0x%03h cycles=%0d pc=0x%02h", name, ins, o.cycles, o.pc);
    endtask

    task automatic all_outs(output logic [31:0] v);
        v = {bus.imem_req, bus.pc, bus.track_select, bus.r_alpha, bus.r_beta, bus.r_gamma,
             bus.alu_op, bus.reg_we, bus.wb_sel, bus.dmem_req, bus.dmem_we, bus.halted,
             bus.illegal};
    endtask

    task automatic do_reset(input string name);
        logic [31:0] v;
        reset_n = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.alu_zero = 1'b0; bus.imem_rdata = '0;
        repeat (2) @(negedge clk);
        all_outs(v);
        check({name, ".outs_in_reset"}, v, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check({name, ".first_req"}, 32'(bus.imem_req), 32'd1);
        check({name, ".pc"}, 32'(bus.pc), 32'h00);
        m_pc = 8'h00;
        $display("txn %-12s reset released", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  h_pc;
        n_vec = 0;
        n_err = 0;
        m_pc = 8'h00;
        reset_n = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.alu_zero = 1'b0; bus.imem_rdata = '0;

        do_reset("reset0");

        // ALU op 6, zero-wait fetch: 4-cycle instruction, pc -> 0x01
        run_instr("alu_1b1", 10'h1B1, 0, 0, 1'b0);
        check("alu_1b1.pc_lit", 32'(bus.pc), 32'h01);
        run_instr("alu_wait2", 10'h05B, 2, 0, 1'b0);
        run_instr("load_d3", 10'h224, 0, 3, 1'b0);
        run_instr("store_d1", 10'h264, 1, 1, 1'b0);
        run_instr("nop", 10'h000, 0, 0, 1'b0);
        run_instr("illegal_c", 10'h300, 0, 0, 1'b0);
        run_instr("illegal_b", 10'h2C0, 1, 0, 1'b0);
        run_instr("alu_1ec", 10'h1EC, 0, 0, 1'b1);
        run_instr("beq_nt", 10'h281, 0, 0, 1'b0);
        run_instr("beq_t_p1", 10'h281, 0, 0, 1'b1);

        // Branch wrap-around around 0xFF
        do_reset("reset1");
        run_instr("beq_to_ff", 10'h282, 0, 0, 1'b1);
        check("beq_to_ff.pc_lit", 32'(bus.pc), 32'hFF);
        run_instr("beq_ff_nt", 10'h282, 0, 0, 1'b0);
        check("beq_ff_nt.pc_lit", 32'(bus.pc), 32'h00);
        run_instr("beq_to_ff2", 10'h282, 0, 0, 1'b1);
        run_instr("beq_ff_t", 10'h282, 0, 0, 1'b1);
        check("beq_ff_t.pc_lit", 32'(bus.pc), 32'hFE);

        // Reset while a STORE is in MEM: request must drop asynchronously
        bus.imem_rdata = 10'h264;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem.req_before", {bus.dmem_req, bus.dmem_we}, 32'h3);
        #2;
        bus.dmem_ack = 1'b1;
        bus.imem_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_mem.req_drop", {bus.dmem_req, bus.dmem_we, bus.imem_req}, 32'h0);
        repeat (2) @(negedge clk);
        all_outs(v);
        check("rst_mem.outs_in_reset", v, 32'd0);
        bus.dmem_ack = 1'b0;
        bus.imem_ack = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mem.first_req", 32'(bus.imem_req), 32'd1);
        check("rst_mem.pc", 32'(bus.pc), 32'h00);
        m_pc = 8'h00;
        $display("txn %-12s reset during MEM", "rst_mem");
        run_instr("nop_restart", 10'h000, 0, 0, 1'b0);

        // Reset while FETCH is requesting
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_fetch.req_drop", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_fetch.first_req", 32'(bus.imem_req), 32'd1);
        check("rst_fetch.pc", 32'(bus.pc), 32'h00);
        m_pc = 8'h00;
        $display("txn %-12s reset during FETCH", "rst_fetch");
        run_instr("alu_after", 10'h1B1, 0, 0, 1'b0);

        // HALT with imem_ack stuck high: everything frozen
        h_pc = m_pc;
        bus.imem_rdata = 10'h3C0;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt.c%0d", i),
                  {bus.halted, bus.imem_req, bus.dmem_req, bus.reg_we, bus.dmem_we, bus.pc},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, h_pc});
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        $display("txn %-12s instr=0x3c0 pc=0x%02h halted=%0b", "halt", bus.pc, bus.halted);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
